// File: rtl/basic_ram_model.sv
// basic_ram_model: byte-addressed, little-endian 32-bit memory with a
// fixed-latency cs/we/oe request and a one-cycle mem_done_out strobe.
// Storage is four byte-lane arrays so sub-word writes need no
// read-modify-write. Reads are right-justified and zero-extended.
module basic_ram_model #(
  parameter int MEM_WORDS = 1024,  // depth in 32-bit words, power of two
  parameter int LATENCY   = 2      // accept edge to mem_done_out, 1..15
) (
  input  logic        clk,
  input  logic        rst,          // synchronous, active-low
  input  logic [31:0] address,
  input  logic [31:0] data_input,
  output logic [31:0] data_output,
  input  logic        cs,
  input  logic        we,
  input  logic        oe,
  input  logic [1:0]  data_size,
  output logic        mem_done_out
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int AW    = IDX_W + 2;  // byte-address bits that matter
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  count_q, count_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        write_q, write_d;
  logic [31:0] rdata_q, rdata_d;
  logic        done_q, done_d;

  logic             accept;
  logic             mem_we;
  logic [3:0]       mem_be;
  logic [31:0]      mem_wdata;
  logic [IDX_W-1:0] idx;
  logic [7:0]       rd_bytes [4];
  logic [31:0]      rd_word;
  logic [31:0]      read_val;

  genvar gi;

  // Address bits above the array wrap around and are deliberately dropped.
  generate
    if (AW < 32) begin : g_unused_addr
      logic unused_addr_bits;
      assign unused_addr_bits = ^address[31:AW];
    end
  endgenerate

  assign accept       = cs & (we | oe);
  assign idx          = addr_q[AW-1:2];
  assign rd_word      = {rd_bytes[3], rd_bytes[2], rd_bytes[1], rd_bytes[0]};
  assign data_output  = rdata_q;
  assign mem_done_out = done_q;

  // Next-state logic: DONE accepts a pending request just like IDLE does, so a
  // master holding cs sees one access every LATENCY+1 cycles while the
  // completion strobe still lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    write_d = write_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          state_d = BUSY;
          count_d = LAT_M1;
          addr_d  = address[AW-1:0];
          wdata_d = data_input;
          size_d  = data_size;
          write_d = we;           // write wins when both we and oe are high
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (count_q == 4'd0) begin
          state_d = DONE;
          done_d  = 1'b1;
          if (write_q) begin
            mem_we = 1'b1;        // writes leave data_output untouched
          end else begin
            rdata_d = read_val;
          end
        end else begin
          count_d = count_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Lane enables and replicated write data for the latched access size.
  always_comb begin
    mem_be    = 4'b1111;
    mem_wdata = wdata_q;
    case (size_q)
      SZ_BYTE: begin
        mem_be    = 4'b0001 << addr_q[1:0];
        mem_wdata = {4{wdata_q[7:0]}};
      end
      SZ_HALF: begin
        mem_be    = addr_q[1] ? 4'b1100 : 4'b0011;
        mem_wdata = {2{wdata_q[15:0]}};
      end
      default: begin
        mem_be    = 4'b1111;
        mem_wdata = wdata_q;
      end
    endcase
  end

  // Read formatting: pick the addressed lane and zero-extend.
  always_comb begin
    read_val = rd_word;
    case (size_q)
      SZ_BYTE: begin
        case (addr_q[1:0])
          2'd0:    read_val = {24'd0, rd_word[7:0]};
          2'd1:    read_val = {24'd0, rd_word[15:8]};
          2'd2:    read_val = {24'd0, rd_word[23:16]};
          default: read_val = {24'd0, rd_word[31:24]};
        endcase
      end
      SZ_HALF: read_val = addr_q[1] ? {16'd0, rd_word[31:16]} : {16'd0, rd_word[15:0]};
      default: read_val = rd_word;
    endcase
  end

  // Control and output registers; the request latches need no reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      count_q <= 4'd0;
      rdata_q <= 32'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      write_q <= write_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
    end
  end

  // One byte-lane array per lane; reset only blocks a commit, never clears.
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_q [MEM_WORDS];

      // Commit this lane's byte when the access completes outside reset.
      always_ff @(posedge clk) begin
        if (rst && mem_we && mem_be[gi]) begin
          lane_q[idx] <= mem_wdata[8*gi +: 8];
        end
      end

      assign rd_bytes[gi] = lane_q[idx];
    end
  endgenerate

endmodule

// File: tb/tb_basic_ram_model.sv
// Directed bench for basic_ram_model: a vector table of single accesses
// plus hand-written handshake and reset-abort sequences.
module tb_basic_ram_model;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] data_input = '0;
  logic [31:0] data_output;
  logic        cs = 1'b0;
  logic        we = 1'b0;
  logic        oe = 1'b0;
  logic [1:0]  data_size = 2'b11;
  logic        mem_done_out;

  int checks = 0;
  int failures = 0;

  localparam int LAT = 2;

  basic_ram_model #(.MEM_WORDS(1024), .LATENCY(LAT)) dut (
    .clk(clk),
    .rst(rst),
    .address(address),
    .data_input(data_input),
    .data_output(data_output),
    .cs(cs),
    .we(we),
    .oe(oe),
    .data_size(data_size),
    .mem_done_out(mem_done_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        w;
    logic        o;
    logic [1:0]  sz;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;   // expected data_output after completion
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  // One access: present for one accept edge, then count edges to the strobe.
  task automatic access(input logic w, input logic o, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] d, output int lat);
    bit seen;
    @(negedge clk);
    cs = 1'b1; we = w; oe = o; data_size = sz; address = a; data_input = d;
    @(posedge clk);
    #1;
    cs = 1'b0; we = 1'b0; oe = 1'b0;
    lat = -1;
    seen = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (!seen) begin
        @(posedge clk);
        #1;
        if (mem_done_out) begin
          lat = i;
          seen = 1'b1;
        end
      end
    end
  endtask

  initial begin
    int lat;
    int pulses [$];
    int ndone;
    logic [31:0] held;

    //         w     o     sz     addr          data          expected data_output
    vecs[0]  = '{1'b1, 1'b0, 2'b11, 32'h0000_0000, 32'hE3A01005, 32'h0000_0000};
    vecs[1]  = '{1'b1, 1'b0, 2'b11, 32'h0000_0004, 32'hE2812003, 32'h0000_0000};
    vecs[2]  = '{1'b0, 1'b1, 2'b11, 32'h0000_0000, 32'h0,        32'hE3A01005};
    vecs[3]  = '{1'b0, 1'b1, 2'b11, 32'h0000_0004, 32'h0,        32'hE2812003};
    vecs[4]  = '{1'b1, 1'b0, 2'b10, 32'h0000_0010, 32'h11223344, 32'hE2812003};
    vecs[5]  = '{1'b0, 1'b1, 2'b00, 32'h0000_0010, 32'h0,        32'h0000_0044};
    vecs[6]  = '{1'b0, 1'b1, 2'b00, 32'h0000_0011, 32'h0,        32'h0000_0033};
    vecs[7]  = '{1'b0, 1'b1, 2'b00, 32'h0000_0012, 32'h0,        32'h0000_0022};
    vecs[8]  = '{1'b0, 1'b1, 2'b00, 32'h0000_0013, 32'h0,        32'h0000_0011};
    vecs[9]  = '{1'b0, 1'b1, 2'b01, 32'h0000_0010, 32'h0,        32'h0000_3344};
    vecs[10] = '{1'b0, 1'b1, 2'b01, 32'h0000_0012, 32'h0,        32'h0000_1122};
    vecs[11] = '{1'b0, 1'b1, 2'b01, 32'h0000_0011, 32'h0,        32'h0000_3344};
    vecs[12] = '{1'b1, 1'b0, 2'b11, 32'h0000_0020, 32'hAABBCCDD, 32'h0000_3344};
    vecs[13] = '{1'b1, 1'b0, 2'b00, 32'h0000_0021, 32'hFFFFFF5A, 32'h0000_3344};
    vecs[14] = '{1'b0, 1'b1, 2'b11, 32'h0000_0020, 32'h0,        32'hAABB5ADD};
    vecs[15] = '{1'b1, 1'b0, 2'b01, 32'h0000_0022, 32'hFFFF1234, 32'hAABB5ADD};
    vecs[16] = '{1'b0, 1'b1, 2'b11, 32'h0000_0020, 32'h0,        32'h12345ADD};
    vecs[17] = '{1'b1, 1'b0, 2'b11, 32'h0000_1000, 32'hDEADBEEF, 32'h12345ADD};
    vecs[18] = '{1'b0, 1'b1, 2'b11, 32'h0000_0000, 32'h0,        32'hDEADBEEF};
    vecs[19] = '{1'b0, 1'b1, 2'b11, 32'h0000_0003, 32'h0,        32'hDEADBEEF};
    vecs[20] = '{1'b0, 1'b1, 2'b00, 32'h0000_1003, 32'h0,        32'h0000_00DE};
    vecs[21] = '{1'b1, 1'b0, 2'b11, 32'h0000_0030, 32'h0000_0000, 32'h0000_00DE};
    vecs[22] = '{1'b0, 1'b1, 2'b01, 32'h0000_0032, 32'h0,        32'h0000_0000};

    // Reset state
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_data_output", data_output, 32'h0);
    check("reset_done", {31'd0, mem_done_out}, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Table of single accesses
    for (int i = 0; i < NV; i++) begin
      access(vecs[i].w, vecs[i].o, vecs[i].sz, vecs[i].a, vecs[i].d, lat);
      check($sformatf("vec%0d_latency", i), lat, LAT);
      check($sformatf("vec%0d_data", i), data_output, vecs[i].exp);
    end

    // cs held high with oe: a strobe every LAT+1 cycles, one cycle wide
    @(negedge clk);
    cs = 1'b1; oe = 1'b1; we = 1'b0; data_size = 2'b11; address = 32'h4;
    for (int i = 1; i <= 15; i++) begin
      @(posedge clk);
      #1;
      if (mem_done_out) pulses.push_back(i);
    end
    @(negedge clk);
    cs = 1'b0; oe = 1'b0;
    repeat (5) @(posedge clk);
    check("held_cs_pulse_count", pulses.size(), 5);
    if (pulses.size() >= 2) begin
      check("held_cs_first_pulse", pulses[0], LAT + 1);
      for (int k = 1; k < pulses.size(); k++)
        check($sformatf("held_cs_gap%0d", k), pulses[k] - pulses[k-1], LAT + 1);
    end
    check("held_cs_read_data", data_output, 32'hE2812003);

    // cs high with neither we nor oe: never completes
    @(negedge clk);
    cs = 1'b1; we = 1'b0; oe = 1'b0;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (mem_done_out) ndone++;
    end
    @(negedge clk);
    cs = 1'b0;
    check("idle_cs_no_done", ndone, 0);

    // we and oe both high: the access is a write
    held = data_output;
    access(1'b1, 1'b1, 2'b11, 32'h0000_0040, 32'hCAFEF00D, lat);
    check("we_oe_latency", lat, LAT);
    check("we_oe_data_output_held", data_output, held);
    access(1'b0, 1'b1, 2'b11, 32'h0000_0040, 32'h0, lat);
    check("we_oe_readback", data_output, 32'hCAFEF00D);

    // Reset during BUSY of a write aborts it
    access(1'b0, 1'b1, 2'b11, 32'h0000_0000, 32'h0, lat);
    check("pre_abort_read", data_output, 32'hDEADBEEF);
    @(negedge clk);
    cs = 1'b1; we = 1'b1; oe = 1'b0; data_size = 2'b11;
    address = 32'h0000_0030; data_input = 32'h0BADF00D;
    @(posedge clk);
    #1;
    cs = 1'b0; we = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      if (mem_done_out) ndone++;
    end
    check("abort_data_output", data_output, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (mem_done_out) ndone++;
    end
    check("abort_no_done", ndone, 0);
    access(1'b0, 1'b1, 2'b11, 32'h0000_0030, 32'h0, lat);
    check("abort_readback_latency", lat, LAT);
    check("abort_not_committed", data_output, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/basic_ram_model.md
Name: basic_ram_model

Overview:
- Behavioural, byte-addressed, little-endian 32-bit memory with a fixed-latency request/ready handshake.
- Sits on the shared system memory bus.
- Serves two masters through an external mux: the file loader, which issues word writes, and the ARMv4 core, which issues instruction and data accesses of byte, halfword or word size.

Parameters:
- MEM_WORDS, 1024: depth in 32-bit words; must be a power of two.
- LATENCY, 2: cycles from request acceptance to mem_done_out; legal range 1..15.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: synchronous reset, active-low (0 = reset).
- address, input, 32: byte address.
- data_input, input, 32: write data, right-justified for sub-word sizes.
- data_output, output, 32: read data, right-justified and zero-extended.
- cs, input, 1: chip select / request.
- we, input, 1: write enable.
- oe, input, 1: output (read) enable.
- data_size, input, 2: 00 byte, 01 halfword, 10 or 11 word.
- mem_done_out, output, 1: one-cycle completion strobe.

Behaviour:
- Reset (rst=0 at a clk edge):
  - state <= IDLE, data_output <= 0, mem_done_out <= 0, latency counter <= 0.
  - Memory array contents are NOT cleared.
  - Reset mid-access aborts it; a pending write is not committed.
- States: IDLE, BUSY, DONE.
- IDLE:
  - If cs=1 and (we|oe)=1, latch address, data_input, data_size and op, then go to BUSY with count=LATENCY-1.
  - op = write if we=1, else read. We has priority when both are high.
  - cs=1 with we=oe=0 is ignored.
- BUSY:
  - Decrement count each cycle.
  - While in BUSY, the cs/we/oe/address/data inputs are ignored; only the latched values are used.
  - When count==0, perform the access and go to DONE.
  - Total cycles from the accepting edge to mem_done_out high = LATENCY.
- Access at completion:
  - word index = latched address[2+log2(MEM_WORDS)-1:2]. Upper address bits are ignored, so accesses wrap modulo 4*MEM_WORDS bytes.
  - Word access: address[1:0] ignored (aligned down).
    - Read: data_output = mem[idx].
    - Write: mem[idx] = data_input.
  - Halfword access: address[0] ignored; lane = address[1] (0 selects bits 15:0, 1 selects bits 31:16).
    - Read: data_output = {16'b0, half}.
    - Write: updates only the selected half, from data_input[15:0].
  - Byte access: lane = address[1:0] (0 selects bits 7:0, up to 3 selecting bits 31:24).
    - Read: data_output = {24'b0, byte}.
    - Write: updates only that byte, from data_input[7:0].
  - A write does not change data_output.
- DONE:
  - mem_done_out=1 for exactly this one cycle, then return to IDLE.
  - If cs is still asserted in IDLE on the next edge, a new access is accepted. A master holding cs therefore gets back-to-back accesses every LATENCY+1 cycles.
- data_output holds its last read value until the next read completes or reset.
- mem_done_out is registered and glitch-free; it is 0 in IDLE and BUSY.
- Memory may be preloaded via $readmemh only as a simulation convenience; synthesis behaviour is unaffected.

Test Plan:
1. Reset, then load via the loader pattern: word writes to 0x0 (0xE3A01005) and 0x4 (0xE2812003), each with size=11, cs=1, we=1.
   - Each mem_done_out pulses exactly LATENCY cycles after acceptance.
   - Word reads of 0x0 and 0x4 return 0xE3A01005 and 0xE2812003.
2. Sub-word reads of word 0x11223344 stored at 0x10.
   - Byte reads at 0x10..0x13 return 0x44, 0x33, 0x22, 0x11.
   - Halfword reads at 0x10 and 0x12 return 0x3344 and 0x1122, with upper bits zero.
3. Sub-word writes to word 0xAABBCCDD stored at 0x20.
   - Byte write 0x5A to 0x21 makes a word read return 0xAABB5ADD.
   - Halfword write 0x1234 to 0x22 then makes a word read return 0x12345ADD.
4. Wrap and alignment with MEM_WORDS=1024.
   - Word write 0xDEADBEEF to 0x1000 makes a word read of 0x0 return 0xDEADBEEF.
   - A word read at 0x3 returns mem[0].
5. Handshake with cs held high continuously and oe=1.
   - mem_done_out pulses every LATENCY+1 cycles.
   - With cs=1 and we=oe=0, mem_done_out is never asserted.
   - With we=oe=1, the access performs a write.
6. Reset mid-access: assert rst=0 during BUSY of a write of 0x0BADF00D to 0x30 whose prior content is 0x00000000.
   - mem_done_out stays 0 and data_output is 0.
   - A subsequent word read of 0x30 returns 0x00000000.
